// File: rtl/sequential_divider_if.sv
// Handshake and result bus of the sequential divider.
// master: requester (drives start and operands); slave: the divider.
interface sequential_divider_if;
    logic        start;
    logic [15:0] inDividend;
    logic [7:0]  inDivisor;
    logic        busy;
    logic        done;
    logic [7:0]  quotient;
    logic [7:0]  remainder;
    logic        overflow;
    logic        div_by_zero;

    modport master (
        output start, inDividend, inDivisor,
        input  busy, done, quotient, remainder, overflow, div_by_zero
    );

    modport slave (
        input  start, inDividend, inDivisor,
        output busy, done, quotient, remainder, overflow, div_by_zero
    );
endinterface

// File: rtl/sequential_divider.sv
// Signed 16/8 restoring divider with a fixed 17-cycle latency.
// Operands are converted to magnitudes on start, 16 MSB-first restoring
// steps produce the magnitude quotient/remainder, and a final FIX cycle
// applies signs, detects overflow / divide-by-zero and registers results.
module sequential_divider (
    input  logic                 clk,
    input  logic                 rst,
    sequential_divider_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [4:0]  cnt_q, cnt_d;
    // Holds the dividend magnitude; quotient bits shift in from the bottom
    // as dividend bits shift out of the top.
    logic [15:0] work_q, work_d;
    // 9-bit partial remainder so the shifted value never wraps before compare.
    logic [8:0]  rem_q, rem_d;
    logic [7:0]  dsr_mag_q, dsr_mag_d;
    logic        dvd_sign_q, dvd_sign_d;
    logic        q_sign_q, q_sign_d;
    logic        dbz_q, dbz_d;

    logic [7:0]  quot_q, quot_d;
    logic [7:0]  rmd_q, rmd_d;
    logic        ovf_q, ovf_d;
    logic        dbz_out_q, dbz_out_d;
    logic        done_q, done_d;

    logic [8:0]  rem_sh;
    logic [8:0]  rem_sub;
    logic        rem_ge;
    logic        ovf_fix;

    // Next-state, datapath step and result formatting.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        work_d     = work_q;
        rem_d      = rem_q;
        dsr_mag_d  = dsr_mag_q;
        dvd_sign_d = dvd_sign_q;
        q_sign_d   = q_sign_q;
        dbz_d      = dbz_q;
        quot_d     = quot_q;
        rmd_d      = rmd_q;
        ovf_d      = ovf_q;
        dbz_out_d  = dbz_out_q;
        done_d     = 1'b0;

        rem_sh  = (rem_q << 1) | {8'd0, work_q[15]};
        rem_ge  = (rem_sh >= {1'b0, dsr_mag_q});
        rem_sub = rem_sh - {1'b0, dsr_mag_q};
        // A negative quotient may reach magnitude 128; a positive one only 127.
        ovf_fix = q_sign_q ? (work_q > 16'd128) : (work_q > 16'd127);

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    dvd_sign_d = bus.inDividend[15];
                    q_sign_d   = bus.inDividend[15] ^ bus.inDivisor[7];
                    work_d     = bus.inDividend[15] ? (16'd0 - bus.inDividend) : bus.inDividend;
                    dsr_mag_d  = bus.inDivisor[7] ? (8'd0 - bus.inDivisor) : bus.inDivisor;
                    dbz_d      = (bus.inDivisor == 8'd0);
                    rem_d      = 9'd0;
                    cnt_d      = 5'd0;
                    state_d    = CALC;
                end
            end
            CALC: begin
                rem_d  = rem_ge ? rem_sub : rem_sh;
                work_d = {work_q[14:0], rem_ge};
                cnt_d  = cnt_q + 5'd1;
                if (cnt_q == 5'd15) begin
                    state_d = FIX;
                end
            end
            FIX: begin
                done_d  = 1'b1;
                state_d = IDLE;
                if (dbz_q) begin
                    quot_d    = 8'd0;
                    rmd_d     = 8'd0;
                    ovf_d     = 1'b0;
                    dbz_out_d = 1'b1;
                end else if (ovf_fix) begin
                    quot_d    = 8'd0;
                    rmd_d     = 8'd0;
                    ovf_d     = 1'b1;
                    dbz_out_d = 1'b0;
                end else begin
                    // Remainder magnitude is below the divisor (<=127), so 8 bits hold it.
                    quot_d    = q_sign_q ? (8'd0 - work_q[7:0]) : work_q[7:0];
                    rmd_d     = dvd_sign_q ? (8'd0 - rem_q[7:0]) : rem_q[7:0];
                    ovf_d     = 1'b0;
                    dbz_out_d = 1'b0;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers; reset clears everything and aborts any division.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= 5'd0;
            work_q     <= 16'd0;
            rem_q      <= 9'd0;
            dsr_mag_q  <= 8'd0;
            dvd_sign_q <= 1'b0;
            q_sign_q   <= 1'b0;
            dbz_q      <= 1'b0;
            quot_q     <= 8'd0;
            rmd_q      <= 8'd0;
            ovf_q      <= 1'b0;
            dbz_out_q  <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            work_q     <= work_d;
            rem_q      <= rem_d;
            dsr_mag_q  <= dsr_mag_d;
            dvd_sign_q <= dvd_sign_d;
            q_sign_q   <= q_sign_d;
            dbz_q      <= dbz_d;
            quot_q     <= quot_d;
            rmd_q      <= rmd_d;
            ovf_q      <= ovf_d;
            dbz_out_q  <= dbz_out_d;
            done_q     <= done_d;
        end
    end

    assign bus.busy        = (state_q == CALC) || (state_q == FIX);
    assign bus.done        = done_q;
    assign bus.quotient    = quot_q;
    assign bus.remainder   = rmd_q;
    assign bus.overflow    = ovf_q;
    assign bus.div_by_zero = dbz_out_q;

endmodule

// File: tb/tb_sequential_divider.sv
// Self-checking bench for sequential_divider: directed cases, divide-by-zero,
// ignored start, reset abort, back-to-back and randomized operands against
// an integer-arithmetic reference model.
module tb_sequential_divider;

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_fail   = 0;

    sequential_divider_if bus ();

    sequential_divider dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Reference: signed integer division truncating toward zero.
    function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output bit ovf, output bit dbz);
        int ai, bi, qi, ri;
        ai = int'($signed(a));
        bi = int'($signed(b));
        q = 8'd0; r = 8'd0; ovf = 1'b0; dbz = 1'b0;
        if (bi == 0) begin
            dbz = 1'b1;
        end else begin
            qi = ai / bi;
            ri = ai % bi;
            if (qi > 127 || qi < -128) ovf = 1'b1;
            else begin
                q = qi[7:0];
                r = ri[7:0];
            end
        end
    endfunction

    // Issues one start and counts edges until done; lat = -1 if done never came.
    task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                           output int lat, output bit busy_bad);
        @(negedge clk);
        bus.inDividend = a;
        bus.inDivisor  = b;
        bus.start      = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        busy_bad = (bus.busy !== 1'b1);
        lat = -1;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat = k;
                if (bus.busy !== 1'b0) busy_bad = 1'b1;
                break;
            end
            if (bus.busy !== 1'b1) busy_bad = 1'b1;
        end
    endtask

    task automatic test_reset;
        bus.start = 1'b1; bus.inDividend = 16'd100; bus.inDivisor = 8'd7;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.overflow, bus.div_by_zero, bus.quotient, bus.remainder} !== 20'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h ovf=%b dbz=%b, want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.overflow, bus.div_by_zero);
        end
        @(negedge clk);
        rst = 1'b0; bus.start = 1'b0;
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_priority: busy=%b, want 0", bus.busy);
        end
    endtask

    task automatic test_directed;
        logic [15:0] ta[11] = '{16'h0064, 16'hFF9C, 16'h0064, 16'hFF00, 16'h0100, 16'h8000,
                                16'h0000, 16'h8000, 16'hFF80, 16'h007F, 16'hFFFF};
        logic [7:0]  tb[11] = '{8'h07, 8'h07, 8'hF9, 8'h02, 8'h02, 8'h80,
                                8'h05, 8'h01, 8'h01, 8'hFF, 8'h02};
        logic [7:0]  tq[11] = '{8'h0E, 8'hF2, 8'hF2, 8'h80, 8'h00, 8'h00,
                                8'h00, 8'h00, 8'h80, 8'h81, 8'h00};
        logic [7:0]  tr[11] = '{8'h02, 8'hFE, 8'h02, 8'h00, 8'h00, 8'h00,
                                8'h00, 8'h00, 8'h00, 8'h00, 8'hFF};
        bit          to[11] = '{0, 0, 0, 0, 1, 1, 0, 1, 0, 0, 0};
        int lat;
        bit bb;
        for (int i = 0; i < 11; i++) begin
            run_div(ta[i], tb[i], lat, bb);
            n_checks++;
            if (lat != 17 || bb) begin
                n_fail++;
                $display("FAIL directed_timing[%0d]: latency=%0d busy_bad=%b, want 17 and 0", i, lat, bb);
            end
            n_checks++;
            if (bus.quotient !== tq[i] || bus.remainder !== tr[i] || bus.overflow !== to[i] || bus.div_by_zero !== 1'b0) begin
                n_fail++;
                $display("FAIL directed_result[%0d] %h/%h: got q=%h r=%h ovf=%b dbz=%b, want q=%h r=%h ovf=%b dbz=0",
                         i, ta[i], tb[i], bus.quotient, bus.remainder, bus.overflow, bus.div_by_zero, tq[i], tr[i], to[i]);
            end
        end
        // done is a single pulse and results hold afterwards.
        @(posedge clk);
        #1;
        n_checks++;
        if (bus.done !== 1'b0 || bus.quotient !== 8'h00 || bus.remainder !== 8'hFF) begin
            n_fail++;
            $display("FAIL done_pulse_hold: done=%b q=%h r=%h, want 0 00 ff", bus.done, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_div_zero_ignore;
        int lat = -1;
        int extra = 0;
        @(negedge clk);
        bus.inDividend = 16'd1234; bus.inDivisor = 8'd0; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            if (k == 4) begin
                @(negedge clk);
                bus.inDividend = 16'd100; bus.inDivisor = 8'd7; bus.start = 1'b1;
            end
            @(posedge clk);
            #1 bus.start = 1'b0;
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
        n_checks++;
        if (lat != 17) begin
            n_fail++;
            $display("FAIL dbz_latency: latency=%0d, want 17", lat);
        end
        n_checks++;
        if (bus.div_by_zero !== 1'b1 || bus.overflow !== 1'b0 || bus.quotient !== 8'h00 || bus.remainder !== 8'h00) begin
            n_fail++;
            $display("FAIL dbz_result: got q=%h r=%h ovf=%b dbz=%b, want 00 00 0 1",
                     bus.quotient, bus.remainder, bus.overflow, bus.div_by_zero);
        end
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1 || bus.busy === 1'b1) extra++;
        end
        n_checks++;
        if (extra != 0 || bus.div_by_zero !== 1'b1) begin
            n_fail++;
            $display("FAIL ignored_start: extra activity cycles=%0d dbz=%b, want 0 and 1", extra, bus.div_by_zero);
        end
    endtask

    task automatic test_abort;
        int dones = 0;
        int lat;
        bit bb;
        @(negedge clk);
        bus.inDividend = 16'd200; bus.inDivisor = 8'd3; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        repeat (4) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if ({bus.busy, bus.done, bus.overflow, bus.div_by_zero, bus.quotient, bus.remainder} !== 20'd0) begin
            n_fail++;
            $display("FAIL abort_outputs: got busy=%b done=%b q=%h r=%h ovf=%b dbz=%b, want all 0",
                     bus.busy, bus.done, bus.quotient, bus.remainder, bus.overflow, bus.div_by_zero);
        end
        @(negedge clk);
        rst = 1'b0;
        for (int k = 0; k < 25; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) dones++;
        end
        n_checks++;
        if (dones != 0) begin
            n_fail++;
            $display("FAIL abort_no_done: done pulses=%0d, want 0", dones);
        end
        run_div(16'd50, 8'd5, lat, bb);
        n_checks++;
        if (lat != 17 || bus.quotient !== 8'h0A || bus.remainder !== 8'h00) begin
            n_fail++;
            $display("FAIL after_abort: latency=%0d q=%h r=%h, want 17 0a 00", lat, bus.quotient, bus.remainder);
        end
    endtask

    task automatic test_back_to_back;
        int lat1 = -1;
        int lat2 = -1;
        @(negedge clk);
        bus.inDividend = 16'd100; bus.inDivisor = 8'd7; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat1 = k;
                break;
            end
        end
        n_checks++;
        if (lat1 != 17 || bus.quotient !== 8'h0E || bus.remainder !== 8'h02) begin
            n_fail++;
            $display("FAIL b2b_first: latency=%0d q=%h r=%h, want 17 0e 02", lat1, bus.quotient, bus.remainder);
        end
        // Start presented in the done cycle itself.
        bus.inDividend = 16'd127; bus.inDivisor = 8'hFF; bus.start = 1'b1;
        @(posedge clk);
        #1 bus.start = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk);
            #1;
            if (bus.done === 1'b1) begin
                lat2 = k;
                break;
            end
        end
        n_checks++;
        if (lat2 != 17 || bus.quotient !== 8'h81 || bus.remainder !== 8'h00 || bus.overflow !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_second: latency=%0d q=%h r=%h ovf=%b, want 17 81 00 0",
                     lat2, bus.quotient, bus.remainder, bus.overflow);
        end
    endtask

    task automatic test_random;
        logic [15:0] a;
        logic [7:0]  b, eq, er;
        bit          eo, ez, bb;
        int          lat;
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(0, 1) == 1) a = 16'($urandom);
            else a = 16'(int'($urandom_range(0, 6000)) - 3000);
            if ($urandom_range(0, 9) == 0) b = 8'd0;
            else b = 8'($urandom);
            model(a, b, eq, er, eo, ez);
            run_div(a, b, lat, bb);
            n_checks++;
            if (lat != 17 || bb || bus.quotient !== eq || bus.remainder !== er ||
                bus.overflow !== eo || bus.div_by_zero !== ez) begin
                n_fail++;
                $display("FAIL random[%0d] %h/%h: lat=%0d busy_bad=%b q=%h r=%h ovf=%b dbz=%b, want 17 0 %h %h %b %b",
                         i, a, b, lat, bb, bus.quotient, bus.remainder, bus.overflow, bus.div_by_zero,
                         eq, er, eo, ez);
            end
        end
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;
        bus.inDividend = 16'd0;
        bus.inDivisor = 8'd0;
        test_reset();
        test_directed();
        test_div_zero_ignore();
        test_abort();
        test_back_to_back();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/sequential_divider.md
SEQUENTIAL_DIVIDER -- requirements
Module: sequential_divider

Interface
REQ-001 Parameters: none; all widths are fixed as listed below.
REQ-002 The block SHALL use one clock; reset is synchronous and active-high.
REQ-003 clk  input  1  clock; all state updates on the rising edge.
REQ-004 rst  input  1  synchronous active-high reset.
REQ-005 start  input  1  request to begin a division; sampled only in IDLE.
REQ-006 inDividend  input  16  signed two's-complement dividend.
REQ-007 inDivisor  input  8  signed two's-complement divisor.
REQ-008 busy  output  1  high while a division is in progress (CALC or FIX).
REQ-009 done  output  1  one-cycle pulse; results valid.
REQ-010 quotient  output  8  signed quotient; held until the next accepted start.
REQ-011 remainder  output  8  signed remainder; held until the next accepted start.
REQ-012 overflow  output  1  the true quotient is outside -128..127.
REQ-013 div_by_zero  output  1  the divisor was 0.

Function
REQ-014 The FSM SHALL have three states: IDLE, CALC and FIX.
REQ-015 IDLE with start=1 at edge N: SHALL capture both operands, the sign of the dividend and the sign of the quotient (XOR of operand signs), convert both operands to magnitudes (16-bit and 8-bit unsigned, so that 0x8000 becomes 32768 and 0x80 becomes 128), clear the 5-bit iteration counter, and go to CALC.
REQ-016 CALC SHALL perform one restoring-division step per clock, MSB first, for exactly 16 clocks.
REQ-017 Each CALC step SHALL shift the partial remainder left by 1, bring in the next dividend bit, and compare against the divisor magnitude.
REQ-018 If the partial remainder is greater than or equal to the divisor magnitude, the step SHALL subtract it and shift a 1 into the quotient; otherwise it SHALL shift a 0 into the quotient.
REQ-019 The partial remainder SHALL be 9 bits wide so that the compare cannot overflow.
REQ-020 After the 16th CALC step, the FSM SHALL go to FIX.
REQ-021 FIX SHALL apply the signs: the quotient is negated if the quotient sign is 1; the remainder takes the sign of the dividend, truncating toward zero.
REQ-022 FIX SHALL set overflow=1 if the signed quotient is outside -128..127 (-128 is legal only when the quotient is negative).
REQ-023 FIX SHALL register quotient, remainder, overflow and div_by_zero, pulse done=1 for the following cycle, and return to IDLE.
REQ-024 Latency SHALL be fixed: start sampled at edge N gives done high in the cycle after edge N+17, for every operand value.
REQ-025 busy SHALL be high after edge N through edge N+17, and low in the done cycle.
REQ-026 Divisor = 0: the block SHALL still take the full fixed latency and then report div_by_zero=1, overflow=0, quotient=0x00, remainder=0x00.
REQ-027 Overflow (divisor nonzero): the block SHALL report overflow=1, div_by_zero=0, quotient=0x00, remainder=0x00.
REQ-028 A start asserted while busy=1 SHALL be ignored, and the operands SHALL NOT be re-sampled.
REQ-029 A start in the done cycle SHALL be accepted, since the FSM is already in IDLE.
REQ-030 Dividend = 0: the result SHALL be quotient 0, remainder 0, with no flags.
REQ-031 Outputs SHALL change only at the FIX edge or on reset.

Reset
REQ-032 rst=1 SHALL force IDLE and clear busy, done, quotient, remainder, overflow, div_by_zero and all internal registers to 0.
REQ-033 rst SHALL take priority over start on the same edge.
REQ-034 rst during CALC or FIX SHALL abort the operation, and no done pulse SHALL follow.

Verification
REQ-035 Case 1: dividend 100 (0x0064) / divisor 7 (0x07) -> quotient 0x0E (14), remainder 0x02, flags 0, done exactly 17 clocks after the start edge.
REQ-036 Case 2: dividend -100 (0xFF9C) / divisor 7 -> quotient 0xF2 (-14), remainder 0xFE (-2); dividend 100 / divisor -7 (0xF9) -> quotient 0xF2, remainder 0x02.
REQ-037 Case 3: dividend -256 (0xFF00) / divisor 2 -> quotient 0x80 (-128), remainder 0x00, overflow 0; dividend 256 (0x0100) / divisor 2 -> overflow 1, quotient 0x00; dividend -32768 (0x8000) / divisor -128 (0x80) -> overflow 1.
REQ-038 Case 4: dividend 1234 / divisor 0 -> div_by_zero 1, quotient 0x00, remainder 0x00, done after 17 clocks; start pulsed mid-CALC -> ignored and the first result is unchanged.
REQ-039 Case 5: rst asserted on the 5th CALC cycle -> busy 0 and all outputs 0 on the next cycle, no done pulse; a following start for 50 / 5 -> quotient 0x0A, remainder 0x00.
REQ-040 Case 6: back-to-back operation, with start held high in the done cycle of 100 / 7 and new operands 127 / -1 -> second done 17 clocks later with quotient 0x81 (-127), remainder 0x00.
